// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Circular trace of retired instructions (cycle, PC, instr,
//               rd, wdata) with PC-match trigger and valid/ready drain port.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CYC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [31:0]              commit_instr,
    input  logic                     commit_we,
    input  logic [4:0]               commit_rd,
    input  logic [XLEN-1:0]          commit_wdata,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     mode,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [CNT_W-1:0]         post_count,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_wdata,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CYC_W-1:0]         cycle
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_RW    = CYC_W + XLEN + 32 + 5 + XLEN;
    localparam logic [c_AW:0]   c_FULL  = DEPTH[c_AW:0];
    localparam logic [CNT_W-1:0] c_REM_LAST = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_TRIG  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             r_overflow;
    logic [CYC_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_remaining;
    logic [c_RW-1:0]  r_mem [DEPTH];

    logic             w_capturing;
    logic             w_full;
    logic             w_write;
    logic             w_drop;
    logic             w_match;
    logic             w_pop;
    logic [c_RW-1:0]  w_rec;
    logic [c_RW-1:0]  w_head;

    assign w_capturing = commit_valid && (r_state == c_ARMED || r_state == c_TRIG);
    assign w_full      = (r_level == c_FULL);
    assign w_write     = w_capturing && (!w_full || !mode);
    assign w_drop      = w_capturing && w_full && mode;
    assign w_match     = trig_en && (commit_pc == trig_pc);
    assign w_pop       = rd_valid && rd_ready;

    // Non-writing instructions store zeros so stale rd/wdata never leak into the trace.
    assign w_rec = {r_cycle, commit_pc, commit_instr,
                    commit_we ? commit_rd : 5'd0,
                    commit_we ? commit_wdata : {XLEN{1'b0}}};

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_cycle     <= '0;
            r_remaining <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (arm) begin
                        r_state    <= c_ARMED;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_level    <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_level  <= r_level - 1'b1;
                    end
                end
                default: begin
                    if (w_write) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        // Wrap mode on a full buffer: the oldest record is overwritten.
                        if (w_full) begin
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_level <= r_level + 1'b1;
                        end
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_state == c_ARMED && w_write && w_match) begin
                        if (post_count == '0) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state     <= c_TRIG;
                            r_remaining <= post_count;
                        end
                    end
                    if (r_state == c_TRIG && w_write) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == c_REM_LAST) begin
                            r_state <= c_DONE;
                        end
                    end
                    // Stop and a stop-mode overflow end capture regardless of trigger progress.
                    if (stop || w_drop) begin
                        r_state <= c_DONE;
                    end
                end
            endcase
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign rd_valid = (r_state == c_DONE) && (r_level != '0);
    assign {rd_cycle, rd_pc, rd_instr, rd_rd, rd_wdata} = w_head;
    assign state    = r_state;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign cycle    = r_cycle;

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable on-chip successor to the cycle-by-cycle simulation register/PC dump for the beaver32rv core.
- Captures one record per retired instruction into a parametrised circular buffer: cycle stamp, PC, instruction, destination register and write data.
- Supports a PC-match trigger with a post-trigger window, plus two full-buffer policies.
- Sits beside the core on the commit/writeback signals. A debug host drains the records through a valid/ready read port.

Parameters:
- XLEN, 32: width of PC and write-data fields.
- DEPTH, 16: number of records. Must be a power of two, at least 2.
- CYC_W, 32: width of the free-running cycle counter and stamp.
- CNT_W, 8: width of the post-trigger count.

Ports:
- clk  in  1  clock. All logic uses the rising edge.
- rst  in  1  synchronous reset, active-high.
- commit_valid  in  1  an instruction retires this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- commit_instr  in  32  encoding of the retiring instruction.
- commit_we  in  1  retiring instruction writes the register file.
- commit_rd  in  5  destination register index.
- commit_wdata  in  XLEN  register write data.
- arm  in  1  one-cycle pulse: clear the buffer and start capture.
- stop  in  1  one-cycle pulse: end capture immediately.
- mode  in  1  0 = wrap (overwrite oldest), 1 = stop when full. Sampled every capture cycle.
- trig_en  in  1  enable the PC-match trigger.
- trig_pc  in  XLEN  trigger PC.
- post_count  in  CNT_W  records to capture after the trigger record. Sampled at the trigger.
- rd_valid  out  1  oldest record is presented.
- rd_ready  in  1  host accepts the presented record.
- rd_cycle  out  CYC_W  cycle stamp of the presented record.
- rd_pc  out  XLEN  PC field of the presented record.
- rd_instr  out  32  instruction field of the presented record.
- rd_rd  out  5  rd field of the presented record. Stored as 0 when commit_we=0.
- rd_wdata  out  XLEN  write-data field. Stored as 0 when commit_we=0.
- state  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE.
- level  out  $clog2(DEPTH)+1  records held.
- overflow  out  1  sticky: at least one record was lost or overwritten.
- cycle  out  CYC_W  free-running cycle count.

Behaviour:
- Reset, any state, mid-capture or mid-readout:
  - state=IDLE; wr/rd pointers=0; level=0; overflow=0; cycle=0; remaining count=0; rd_valid=0.
  - Buffer RAM contents are not cleared and are don't-care.
- cycle increments by 1 every non-reset cycle and wraps modulo 2^CYC_W.
- Capture happens in ARMED or TRIGGERED when commit_valid=1:
  - The record {cycle, commit_pc, commit_instr, we?rd:0, we?wdata:0} is written at wr_ptr.
  - The cycle field is the pre-increment value of that cycle.
  - level and pointers update at the next edge, giving 1-cycle latency to level and to rd_valid.
- Full buffer (level=DEPTH) with a capture request:
  - mode=0: overwrite the oldest record; wr_ptr and rd_ptr both advance; level stays DEPTH; overflow<=1.
  - mode=1: record dropped; overflow<=1; state goes to DONE.
- Pointer wrap is modulo DEPTH.
- State transitions:
  - IDLE --arm--> ARMED. The buffer is cleared: pointers=0, level=0, overflow=0.
  - ARMED --(trig_en && commit_valid && commit_pc==trig_pc)--> the trigger record is captured, then:
    - if post_count==0: DONE;
    - otherwise TRIGGERED, with remaining=post_count.
  - TRIGGERED: each captured record decrements remaining. The capture that brings remaining to 0 moves the state to DONE. Further trigger matches are ignored.
  - ARMED/TRIGGERED --stop--> DONE. A commit in the same cycle as stop is still captured.
  - DONE --arm--> ARMED with the buffer cleared, even if unread records remain.
- arm is ignored in ARMED/TRIGGERED. stop is ignored in IDLE/DONE.
- If arm and stop are asserted together: in ARMED/TRIGGERED stop wins; in IDLE/DONE arm wins.
- Readout:
  - rd_valid = (state==DONE) && (level!=0).
  - rd_* are a combinational read of the entry at rd_ptr and are stable while rd_valid=1 and rd_ready=0.
  - A pop occurs on rd_valid && rd_ready: rd_ptr+1 and level-1 at the next edge.
  - At level=0, rd_ready has no effect.
- Commits outside ARMED/TRIGGERED are ignored.

Test Plan:
- Basic trigger: DEPTH=16, mode=0, trig_pc=0x40, post_count=2. Commits at PCs 0x00,0x04,...,0x4C, arm first.
  -> Trigger at 0x40; records captured through PC 0x48; state=DONE; level=19 clipped to 16; overflow=1. Readout order is PCs 0x0C..0x48 with strictly increasing rd_cycle.
- Stop-when-full: mode=1, trig_en=0, 20 consecutive commits.
  -> level=16 after commit 16; commit 17 dropped; state=DONE; overflow=1. Readout yields the first 16 PCs in order.
- Write-suppression: a store commit (commit_we=0, rd=5, wdata=0xDEAD) followed by addi x3 (we=1, wdata=7), then stop.
  -> Records read back {rd=0, wdata=0} and {rd=3, wdata=7}.
- Handshake backpressure: DONE with level=3; hold rd_ready=0 for 4 cycles, then toggle it 1/0.
  -> rd_* are held constant while stalled; exactly one pop per ready-high cycle; rd_valid falls after the third pop.
- Simultaneous and reset edge cases: arm+stop together in ARMED -> DONE. arm+stop together in DONE -> ARMED with level=0. rst asserted in TRIGGERED with level=5 -> next cycle state=0, level=0, overflow=0, cycle=0.
- post_count=0 trigger on the first commit -> DONE with level=1, and that record's PC equals trig_pc.
